// File: rtl/variable_msg_sender.sv
// Arduino-link message sender: 8-byte header (sync, count, ID, sequence) followed by
// 0..MAX_DATA_BYTES payload bytes fetched from an external sample RAM.
module variable_msg_sender #(
  parameter logic [15:0] SYNC           = 16'h1234,
  parameter int unsigned MAX_DATA_BYTES = 256,
  parameter int unsigned LEN_WIDTH      = 9,
  parameter int unsigned ADDR_WIDTH     = 8
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  Send,
  input  logic [15:0]           MsgID,
  input  logic [15:0]           SeqNumber,
  input  logic [LEN_WIDTH-1:0]  DataLength,
  input  logic                  P2S_Empty,
  input  logic [7:0]            RamData,
  output logic                  Ready,
  output logic                  Done,
  output logic                  LoadByte,
  output logic [7:0]            MsgByte,
  output logic                  RamRead,
  output logic [ADDR_WIDTH-1:0] RamAddr
);

  localparam int unsigned IDX_WIDTH = LEN_WIDTH + 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(MAX_DATA_BYTES);
  localparam logic [IDX_WIDTH-1:0] HDR_BYTES = IDX_WIDTH'(8);

  typedef enum logic [2:0] {
    IDLE, WAIT_EMPTY, FETCH, CAPTURE, LOAD, GUARD, DONE
  } state_t;

  state_t                state, nextState;
  logic [15:0]           msgIdQ, seqQ, count;
  logic [LEN_WIDTH-1:0]  lenQ, lenClamped;
  logic [IDX_WIDTH-1:0]  byteIdx;
  logic                  accept, isHeader, isLast;
  logic [7:0]            headerByte;
  logic                  readyD, doneD, loadByteD, ramReadD;
  logic [7:0]            msgByteD;
  logic [ADDR_WIDTH-1:0] ramAddrD;

  assign accept     = (state == IDLE) && Send;
  assign lenClamped = (DataLength > MAX_LEN) ? MAX_LEN : DataLength;
  assign count      = 16'(HDR_BYTES) + 16'(lenQ);
  assign isHeader   = byteIdx < HDR_BYTES;
  assign isLast     = byteIdx == (HDR_BYTES + IDX_WIDTH'(lenQ) - IDX_WIDTH'(1));

  // Header byte for the current index, little-endian per 16-bit field
  always_comb begin
    headerByte = 8'h00;
    case (byteIdx[2:0])
      3'd0:    headerByte = SYNC[7:0];
      3'd1:    headerByte = SYNC[15:8];
      3'd2:    headerByte = count[7:0];
      3'd3:    headerByte = count[15:8];
      3'd4:    headerByte = msgIdQ[7:0];
      3'd5:    headerByte = msgIdQ[15:8];
      3'd6:    headerByte = seqQ[7:0];
      default: headerByte = seqQ[15:8];
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:       if (Send) nextState = WAIT_EMPTY;
      WAIT_EMPTY: if (P2S_Empty) nextState = isHeader ? LOAD : FETCH;
      FETCH:      nextState = CAPTURE;
      CAPTURE:    nextState = LOAD;
      LOAD:       nextState = GUARD;
      GUARD:      nextState = isLast ? DONE : WAIT_EMPTY;
      DONE:       nextState = IDLE;
      default:    nextState = IDLE;
    endcase
  end

  // Next values of the registered outputs, aligned with the state being entered
  always_comb begin
    readyD    = (nextState == IDLE);
    doneD     = (nextState == DONE);
    loadByteD = (nextState == LOAD);
    ramReadD  = (nextState == FETCH);
    msgByteD  = MsgByte;
    ramAddrD  = RamAddr;
    if (state == WAIT_EMPTY && nextState == LOAD) msgByteD = headerByte;
    if (state == CAPTURE) msgByteD = RamData;
    if (nextState == FETCH) ramAddrD = ADDR_WIDTH'(byteIdx - HDR_BYTES);
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      Ready    <= 1'b1;
      Done     <= 1'b0;
      LoadByte <= 1'b0;
      RamRead  <= 1'b0;
      MsgByte  <= 8'h00;
      RamAddr  <= '0;
    end else begin
      Ready    <= readyD;
      Done     <= doneD;
      LoadByte <= loadByteD;
      RamRead  <= ramReadD;
      MsgByte  <= msgByteD;
      RamAddr  <= ramAddrD;
    end
  end

  // Message parameters are frozen at acceptance; index advances after each guard cycle
  always_ff @(posedge Clock) begin
    if (Clear) begin
      msgIdQ  <= '0;
      seqQ    <= '0;
      lenQ    <= '0;
      byteIdx <= '0;
    end else if (accept) begin
      msgIdQ  <= MsgID;
      seqQ    <= SeqNumber;
      lenQ    <= lenClamped;
      byteIdx <= '0;
    end else if (state == GUARD && !isLast) begin
      byteIdx <= byteIdx + IDX_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_variable_msg_sender.sv
// Randomised bench for variable_msg_sender: per-message byte/timing model driven by the
// recorded P2S_Empty history, compared against the observed serializer and RAM traffic.
module tb_variable_msg_sender;

  localparam int MAXB   = 256;
  localparam int HIST   = 8192;
  localparam int BUDGET = 8000;

  logic       Clock = 1'b0;
  logic       Clear, Send, P2S_Empty;
  logic [15:0] MsgID, SeqNumber;
  logic [8:0] DataLength;
  logic [7:0] RamData;
  logic       Ready, Done, LoadByte, RamRead;
  logic [7:0] MsgByte;
  logic [7:0] RamAddr;

  variable_msg_sender dut (
    .Clock(Clock), .Clear(Clear), .Send(Send), .MsgID(MsgID), .SeqNumber(SeqNumber),
    .DataLength(DataLength), .P2S_Empty(P2S_Empty), .RamData(RamData),
    .Ready(Ready), .Done(Done), .LoadByte(LoadByte), .MsgByte(MsgByte),
    .RamRead(RamRead), .RamAddr(RamAddr)
  );

  always #5 Clock = ~Clock;

  // Sample RAM: data valid the cycle after the read strobe
  logic [7:0] ram [0:MAXB-1];
  always @(posedge Clock) if (RamRead) RamData <= ram[RamAddr];

  int checks = 0;
  int errors = 0;

  bit         empHist   [HIST];
  bit         readyHist [HIST];
  int         histLen;
  logic [7:0] gotByte[$];
  int         gotLoad[$], gotAddr[$], gotRd[$], gotDone[$];
  int         abortCyc;
  bit         timedOut;
  logic       snapReady, snapDone, snapLoad, snapRd;
  logic [7:0] snapByte, snapAddr;

  logic [7:0] expByte[$];
  int         expLoad[$], expAddr[$], expRd[$];
  int         expDone;
  bit         expComplete;

  // Drive one message (Send in cycle 0) and record everything the DUT does
  task automatic runMsg(input logic [15:0] id, input logic [15:0] seq, input int len,
                        input int emode, input bit stall, input bit spam, input int abortRd);
    int c, stallLeft, endCyc;
    bit stallDone;
    gotByte.delete(); gotLoad.delete(); gotAddr.delete(); gotRd.delete(); gotDone.delete();
    abortCyc = -1; timedOut = 0; stallLeft = 0; stallDone = 0; endCyc = -1; c = 0;
    while (1) begin
      @(posedge Clock); #1;
      Clear = 1'b0;
      if (c == 0) begin
        Send = 1'b1; MsgID = id; SeqNumber = seq; DataLength = 9'(len);
      end else if (spam) begin
        Send = Done ? 1'b1 : (!Ready ? 1'($urandom_range(0, 1)) : 1'b0);
        MsgID = 16'($urandom); SeqNumber = 16'($urandom); DataLength = 9'($urandom);
      end else begin
        Send = 1'b0;
      end
      if (abortRd >= 0 && abortCyc < 0 && gotAddr.size() == abortRd) begin
        Clear = 1'b1; abortCyc = c;
      end
      if (stall && !stallDone && gotByte.size() == 3) begin
        stallLeft = 10; stallDone = 1;
      end
      if (stallLeft > 0) begin
        P2S_Empty = 1'b0; stallLeft--;
      end else if (emode == 1) P2S_Empty = ($urandom_range(0, 2) != 0);
      else P2S_Empty = 1'b1;
      @(negedge Clock);
      empHist[c] = P2S_Empty;
      readyHist[c] = Ready;
      if (LoadByte) begin gotByte.push_back(MsgByte); gotLoad.push_back(c); end
      if (RamRead) begin gotAddr.push_back(int'(RamAddr)); gotRd.push_back(c); end
      if (Done) begin gotDone.push_back(c); if (endCyc < 0) endCyc = c + 4; end
      if (abortCyc >= 0 && c == abortCyc + 1) begin
        snapReady = Ready; snapDone = Done; snapLoad = LoadByte; snapRd = RamRead;
        snapByte = MsgByte; snapAddr = RamAddr;
      end
      if (abortCyc >= 0 && endCyc < 0) endCyc = abortCyc + 20;
      c++;
      histLen = c;
      if (endCyc >= 0 && c > endCyc) break;
      if (c >= BUDGET) begin timedOut = 1; break; end
    end
    Send = 1'b0; Clear = 1'b0; P2S_Empty = 1'b1;
  endtask

  // Reference: each byte waits from (previous load + 2) for the first cycle with
  // P2S_Empty high; header bytes load 1 cycle later, payload bytes 3 cycles later.
  task automatic buildExpected(input logic [15:0] id, input logic [15:0] seq, input int len);
    int L, total, w, t;
    logic [15:0] words [4];
    expByte.delete(); expLoad.delete(); expAddr.delete(); expRd.delete();
    expComplete = 1; expDone = -1;
    L = (len > MAXB) ? MAXB : len;
    total = 8 + L;
    words[0] = 16'h1234; words[1] = 16'(8 + L); words[2] = id; words[3] = seq;
    w = 1;
    for (int idx = 0; idx < total; idx++) begin
      t = w;
      while (t < histLen && !empHist[t]) t++;
      if (t >= histLen) begin expComplete = 0; break; end
      if (idx < 8) begin
        expByte.push_back((idx % 2 == 1) ? words[idx / 2][15:8] : words[idx / 2][7:0]);
        expLoad.push_back(t + 1);
      end else begin
        expByte.push_back(ram[idx - 8]);
        expRd.push_back(t + 1);
        expAddr.push_back(idx - 8);
        expLoad.push_back(t + 3);
      end
      w = expLoad[expLoad.size() - 1] + 2;
    end
    if (expComplete) expDone = w;
  endtask

  task automatic test_reset();
    Clear = 1'b1; Send = 1'b0; MsgID = '0; SeqNumber = '0; DataLength = '0; P2S_Empty = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", Ready); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (LoadByte !== 1'b0) begin errors++; $display("FAIL reset_load got %b want 0", LoadByte); end
    checks++; if (RamRead !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", RamRead); end
    checks++; if (MsgByte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", MsgByte); end
    checks++; if (RamAddr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", RamAddr); end
    @(posedge Clock); #1;
    Clear = 1'b0;
  endtask

  task automatic test_header_only();
    logic [7:0] lit [8];
    lit = '{8'h34, 8'h12, 8'h08, 8'h00, 8'h64, 8'h00, 8'h05, 8'h00};
    runMsg(16'h0064, 16'h0005, 0, 0, 0, 0, -1);
    buildExpected(16'h0064, 16'h0005, 0);
    checks++; if (timedOut !== 1'b0) begin errors++; $display("FAIL hdr_timeout got %b want 0", timedOut); end
    checks++; if (gotByte.size() != 8) begin errors++; $display("FAIL hdr_count got %0d want 8", gotByte.size()); end
    for (int i = 0; i < 8 && i < gotByte.size(); i++) begin
      checks++;
      if (gotByte[i] !== lit[i] || gotLoad[i] != expLoad[i]) begin
        errors++; $display("FAIL hdr_byte%0d got %h@%0d want %h@%0d", i, gotByte[i], gotLoad[i], lit[i], expLoad[i]);
      end
    end
    checks++; if (gotLoad.size() < 1 || gotLoad[0] != 2) begin errors++; $display("FAIL hdr_latency got %0d loads want first at 2", gotLoad.size()); end
    checks++; if (gotRd.size() != 0) begin errors++; $display("FAIL hdr_ramread got %0d want 0", gotRd.size()); end
    checks++; if (gotDone.size() != 1 || gotDone[0] != expDone) begin errors++; $display("FAIL hdr_done got %0d pulses want 1@%0d", gotDone.size(), expDone); end
    checks++; if (readyHist[expDone] !== 1'b0 || readyHist[expDone + 1] !== 1'b1) begin errors++; $display("FAIL hdr_ready got %b%b want 01", readyHist[expDone], readyHist[expDone + 1]); end
  endtask

  task automatic test_payload();
    for (int i = 0; i < MAXB; i++) ram[i] = 8'(8'hA0 + i);
    runMsg(16'h0101, 16'h1234, 4, 0, 0, 0, -1);
    buildExpected(16'h0101, 16'h1234, 4);
    checks++; if (timedOut !== 1'b0 || gotByte.size() != 12) begin errors++; $display("FAIL pay_count got %0d want 12", gotByte.size()); end
    for (int i = 0; i < expByte.size() && i < gotByte.size(); i++) begin
      checks++;
      if (gotByte[i] !== expByte[i] || gotLoad[i] != expLoad[i]) begin
        errors++; $display("FAIL pay_byte%0d got %h@%0d want %h@%0d", i, gotByte[i], gotLoad[i], expByte[i], expLoad[i]);
      end
    end
    checks++; if (gotAddr.size() != 4) begin errors++; $display("FAIL pay_reads got %0d want 4", gotAddr.size()); end
    for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++) begin
      checks++;
      if (gotAddr[i] != expAddr[i] || gotRd[i] != expRd[i]) begin
        errors++; $display("FAIL pay_addr%0d got %0d@%0d want %0d@%0d", i, gotAddr[i], gotRd[i], expAddr[i], expRd[i]);
      end
    end
    checks++; if (gotDone.size() != 1 || gotDone[0] != expDone) begin errors++; $display("FAIL pay_done got %0d pulses want 1@%0d", gotDone.size(), expDone); end
  endtask

  task automatic test_backpressure();
    logic [15:0] id, seq;
    int len;
    for (int i = 0; i < MAXB; i++) ram[i] = 8'($urandom);
    id = 16'($urandom); seq = 16'($urandom); len = $urandom_range(4, 20);
    runMsg(id, seq, len, 1, 1, 0, -1);
    buildExpected(id, seq, len);
    checks++; if (timedOut !== 1'b0 || expComplete !== 1'b1) begin errors++; $display("FAIL bp_timeout got %b want 0", timedOut); end
    checks++; if (gotByte.size() != expByte.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", gotByte.size(), expByte.size()); end
    for (int i = 0; i < expByte.size() && i < gotByte.size(); i++) begin
      checks++;
      if (gotByte[i] !== expByte[i] || gotLoad[i] != expLoad[i]) begin
        errors++; $display("FAIL bp_byte%0d got %h@%0d want %h@%0d", i, gotByte[i], gotLoad[i], expByte[i], expLoad[i]);
      end
    end
    checks++; if (gotRd.size() != expRd.size()) begin errors++; $display("FAIL bp_reads got %0d want %0d", gotRd.size(), expRd.size()); end
    checks++; if (gotDone.size() != 1 || gotDone[0] != expDone) begin errors++; $display("FAIL bp_done got %0d pulses want 1@%0d", gotDone.size(), expDone); end
  endtask

  task automatic test_clamp();
    int bad;
    for (int i = 0; i < MAXB; i++) ram[i] = 8'($urandom);
    runMsg(16'hBEEF, 16'h0F0F, 300, 0, 0, 1, -1);
    buildExpected(16'hBEEF, 16'h0F0F, 300);
    checks++; if (timedOut !== 1'b0 || gotByte.size() != 264) begin errors++; $display("FAIL clamp_count got %0d want 264", gotByte.size()); end
    checks++; if (gotByte.size() < 4 || gotByte[2] !== 8'h08 || gotByte[3] !== 8'h01) begin errors++; $display("FAIL clamp_countfield got %0d bytes want 0108", gotByte.size()); end
    bad = 0;
    for (int i = 0; i < expByte.size() && i < gotByte.size(); i++)
      if (gotByte[i] !== expByte[i] || gotLoad[i] != expLoad[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL clamp_bytes got %0d wrong want 0", bad); end
    bad = 0;
    for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++)
      if (gotAddr[i] != expAddr[i] || gotRd[i] != expRd[i]) bad++;
    checks++; if (bad != 0 || gotAddr.size() != 256) begin errors++; $display("FAIL clamp_reads got %0d reads %0d wrong want 256 0", gotAddr.size(), bad); end
    checks++; if (gotDone.size() != 1 || gotDone[0] != expDone) begin errors++; $display("FAIL clamp_done got %0d pulses want 1@%0d", gotDone.size(), expDone); end
  endtask

  task automatic test_abort();
    int late;
    for (int i = 0; i < MAXB; i++) ram[i] = 8'($urandom);
    runMsg(16'h5A5A, 16'h0707, 8, 0, 0, 0, 3);
    buildExpected(16'h5A5A, 16'h0707, 8);
    checks++; if (abortCyc < 0) begin errors++; $display("FAIL abort_trigger got %0d reads want 3", gotAddr.size()); end
    checks++; if ({snapReady, snapDone, snapLoad, snapRd, snapByte, snapAddr} !== {4'b1000, 8'h00, 8'h00})
      begin errors++; $display("FAIL abort_outputs got %b%b%b%b %h %h want 1000 00 00", snapReady, snapDone, snapLoad, snapRd, snapByte, snapAddr); end
    checks++; if (gotByte.size() != 10) begin errors++; $display("FAIL abort_count got %0d want 10", gotByte.size()); end
    for (int i = 0; i < 10 && i < gotByte.size(); i++) begin
      checks++;
      if (gotByte[i] !== expByte[i]) begin errors++; $display("FAIL abort_byte%0d got %h want %h", i, gotByte[i], expByte[i]); end
    end
    late = 0;
    foreach (gotLoad[i]) if (gotLoad[i] > abortCyc) late++;
    checks++; if (late != 0 || gotDone.size() != 0) begin errors++; $display("FAIL abort_quiet got %0d loads %0d done want 0 0", late, gotDone.size()); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] id, seq;
    int len, bad;
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < MAXB; i++) ram[i] = 8'($urandom);
      id = 16'($urandom); seq = 16'($urandom); len = $urandom_range(0, 12);
      runMsg(id, seq, len, int'($urandom_range(0, 1)), 0, 0, -1);
      buildExpected(id, seq, len);
      bad = 0;
      for (int i = 0; i < expByte.size() && i < gotByte.size(); i++)
        if (gotByte[i] !== expByte[i] || gotLoad[i] != expLoad[i]) bad++;
      for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++)
        if (gotAddr[i] != expAddr[i] || gotRd[i] != expRd[i]) bad++;
      checks++;
      if (timedOut || bad != 0 || gotByte.size() != expByte.size() || gotAddr.size() != expAddr.size()) begin
        errors++; $display("FAIL b2b%0d got %0d bytes %0d wrong want %0d bytes 0 wrong", m, gotByte.size(), bad, expByte.size());
      end
      checks++; if (gotDone.size() != 1 || gotDone[0] != expDone) begin errors++; $display("FAIL b2b%0d_done got %0d pulses want 1@%0d", m, gotDone.size(), expDone); end
    end
  endtask

  initial begin
    test_reset();
    test_header_only();
    test_payload();
    test_backpressure();
    test_clamp();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
